// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity checker.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_checker_sat_counter.sv
// Saturating up-counter: holds at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // count register, sticks at 2^W-1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/serial_parity_checker.sv
// Reassembles a serial frame of DATA_W data bits plus one parity bit, checks
// parity, presents the word with valid/ready and counts parity errors.
module serial_parity_checker #(
  parameter int DATA_W    = 4,
  parameter int ERR_CNT_W = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 sof,
  output logic                 bit_ready,
  output logic [DATA_W-1:0]    data_out,
  output logic                 par_ok,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  import serial_parity_pkg::*;

  localparam int IDX_W = $clog2(DATA_W) + 1;
  localparam state_t FIRST_NXT = (DATA_W == 1) ? PARITY : DATA;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_par;
  logic [DATA_W-1:0]  r_data;
  logic               r_par_ok;
  logic               r_out_valid;
  logic               w_accept;
  logic               w_last_data;
  logic               w_par_ok_nxt;
  logic               w_err_inc;
  logic [DATA_W-1:0]  w_bit_mask;

  assign w_accept     = bit_valid & bit_ready;
  assign w_last_data  = (r_idx == IDX_W'(DATA_W - 1));
  assign w_par_ok_nxt = ((r_par ^ bit_in) == ODD);
  assign w_err_inc    = w_accept & ~sof & (r_state == PARITY) & ~w_par_ok_nxt;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic; sof on any accepted bit restarts the frame
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && sof) w_state_nxt = FIRST_NXT;
        else                 w_state_nxt = IDLE;
      end
      DATA: begin
        if (w_accept && sof)             w_state_nxt = FIRST_NXT;
        else if (w_accept && w_last_data) w_state_nxt = PARITY;
        else                              w_state_nxt = DATA;
      end
      PARITY: begin
        if (w_accept && sof) w_state_nxt = FIRST_NXT;
        else if (w_accept)   w_state_nxt = HOLD;
        else                 w_state_nxt = PARITY;
      end
      HOLD: begin
        if (out_ready) w_state_nxt = IDLE;
        else           w_state_nxt = HOLD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // output decode
  always_comb begin
    bit_ready = 1'b1;
    case (r_state)
      HOLD:    bit_ready = 1'b0;
      default: bit_ready = 1'b1;
    endcase
  end

  // one-hot slot selected by the bit index
  always_comb begin
    w_bit_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_bit_mask[i] = (r_idx == IDX_W'(i));
    end
  end

  // datapath: word assembly, running parity and the result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_idx       <= '0;
      r_par       <= 1'b0;
      r_par_ok    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept && sof) begin
      r_data <= DATA_W'(bit_in);
      r_idx  <= IDX_W'(1);
      r_par  <= bit_in;
    end else if (w_accept && (r_state == DATA)) begin
      r_data <= (r_data & ~w_bit_mask) | (w_bit_mask & {DATA_W{bit_in}});
      r_idx  <= r_idx + IDX_W'(1);
      r_par  <= r_par ^ bit_in;
    end else if (w_accept && (r_state == PARITY)) begin
      r_par_ok    <= w_par_ok_nxt;
      r_out_valid <= 1'b1;
    end else if ((r_state == HOLD) && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_err_inc),
    .count (err_cnt)
  );

  assign data_out  = r_data;
  assign par_ok    = r_par_ok;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Randomised and directed bench for serial_parity_checker against a frame-level model.
module tb_serial_parity_checker;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic sof = 1'b0;
  logic out_ready = 1'b0;

  logic          a_bit_ready, a_par_ok, a_out_valid;
  logic [DW-1:0] a_data_out;
  logic [7:0]    a_err_cnt;
  logic          b_bit_ready, b_par_ok, b_out_valid;
  logic [DW-1:0] b_data_out;
  logic [1:0]    b_err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(DW), .ERR_CNT_W(8), .ODD(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .bit_ready(a_bit_ready), .data_out(a_data_out), .par_ok(a_par_ok),
    .out_valid(a_out_valid), .out_ready(out_ready), .err_cnt(a_err_cnt)
  );

  serial_parity_checker #(.DATA_W(DW), .ERR_CNT_W(2), .ODD(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .bit_ready(b_bit_ready), .data_out(b_data_out), .par_ok(b_par_ok),
    .out_valid(b_out_valid), .out_ready(out_ready), .err_cnt(b_err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level reference: collect accepted bits, evaluate the whole frame at its parity bit
  logic          m_pending = 1'b0;
  logic          m_active = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_even_ok = 1'b0;
  int            m_err_a = 0;
  int            m_err_b = 0;
  logic          m_q[$];

  always @(posedge clk) begin
    logic x;
    if (rst) begin
      m_pending = 1'b0; m_active = 1'b0; m_q.delete();
      m_err_a = 0; m_err_b = 0;
    end else if (m_pending) begin
      if (out_ready) m_pending = 1'b0;
    end else if (bit_valid) begin
      if (sof) begin
        m_q.delete(); m_q.push_back(bit_in); m_active = 1'b1;
      end else if (m_active) begin
        if (m_q.size() < DW) begin
          m_q.push_back(bit_in);
        end else begin
          x = bit_in;
          for (int i = 0; i < DW; i++) begin
            m_data[i] = m_q[i];
            x = x ^ m_q[i];
          end
          m_even_ok = (x == 1'b0);
          if (!m_even_ok && m_err_a < 255) m_err_a++;
          if (m_even_ok && m_err_b < 3) m_err_b++;
          m_pending = 1'b1; m_active = 1'b0; m_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("a_out_valid", 32'(a_out_valid), 32'(m_pending));
      check_eq("b_out_valid", 32'(b_out_valid), 32'(m_pending));
      check_eq("a_bit_ready", 32'(a_bit_ready), 32'(!m_pending));
      check_eq("b_bit_ready", 32'(b_bit_ready), 32'(!m_pending));
      check_eq("a_err_cnt", 32'(a_err_cnt), 32'(m_err_a));
      check_eq("b_err_cnt", 32'(b_err_cnt), 32'(m_err_b));
      if (m_pending) begin
        check_eq("a_data_out", 32'(a_data_out), 32'(m_data));
        check_eq("b_data_out", 32'(b_data_out), 32'(m_data));
        check_eq("a_par_ok", 32'(a_par_ok), 32'(m_even_ok));
        check_eq("b_par_ok", 32'(b_par_ok), 32'(!m_even_ok));
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic s, input logic b, input logic rdy);
    rst = r; bit_valid = v; sof = s; bit_in = b; out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input int gap);
    for (int i = 0; i < DW; i++) begin
      drive(1'b0, 1'b1, (i == 0), d[i], 1'b0);
      repeat (gap) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, p, 1'b0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_data", 32'(a_data_out), 32'h0);
    check_eq("rst_par_ok", 32'(a_par_ok), 32'h0);
    check_eq("rst_out_valid", 32'(a_out_valid), 32'h0);
    check_eq("rst_bit_ready", 32'(a_bit_ready), 32'h1);
    check_eq("rst_err", 32'(a_err_cnt), 32'h0);

    // good frame 1,0,1,1 + parity 1, then backpressure
    send_frame(4'b1101, 1'b1, 0);
    check_eq("good_valid", 32'(a_out_valid), 32'h1);
    check_eq("good_data", 32'(a_data_out), 32'hd);
    check_eq("good_par_ok", 32'(a_par_ok), 32'h1);
    check_eq("good_err", 32'(a_err_cnt), 32'h0);
    repeat (5) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("bp_data", 32'(a_data_out), 32'hd);
    check_eq("bp_ready", 32'(a_bit_ready), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("release_valid", 32'(a_out_valid), 32'h0);
    check_eq("release_ready", 32'(a_bit_ready), 32'h1);

    // bad parity: 1,1,0,0 + parity 1
    send_frame(4'b0011, 1'b1, 0);
    check_eq("bad_data", 32'(a_data_out), 32'h3);
    check_eq("bad_par_ok", 32'(a_par_ok), 32'h0);
    check_eq("bad_err", 32'(a_err_cnt), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // resync: sof+1, 0, then sof+0, 1, 1, 1, parity 1
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1110, 1'b1, 0);
    check_eq("resync_data", 32'(a_data_out), 32'he);
    check_eq("resync_par_ok", 32'(a_par_ok), 32'h1);
    check_eq("resync_err", 32'(a_err_cnt), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // stray bits in IDLE, then a frame with 3-cycle gaps
    repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("stray_valid", 32'(a_out_valid), 32'h0);
    send_frame(4'b1101, 1'b1, 3);
    check_eq("gap_data", 32'(a_data_out), 32'hd);
    check_eq("gap_par_ok", 32'(a_par_ok), 32'h1);

    // reset while holding a word
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("hold_rst_valid", 32'(a_out_valid), 32'h0);
    check_eq("hold_rst_err", 32'(a_err_cnt), 32'h0);

    // five frames failing odd parity saturate the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      send_frame(4'b1101, 1'b1, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_eq("sat_err_b", 32'(b_err_cnt), 32'h3);
    check_eq("sat_err_a", 32'(a_err_cnt), 32'h0);

    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
